// File: rtl/fpu_result_arbiter_pkg.sv
// Shared FPU result-path definitions.
//   - FPU_N_UNITS / FPU_UID_W : default number of execution sub-units and id width
//   - FPU_UNIT_*              : index of each sub-unit on the result arbiter
//   - fpu_result_t            : one buffered result (value, exception flags, source unit)
package fpu_result_arbiter_pkg;

    localparam int FPU_N_UNITS  = 6;
    localparam int FPU_UID_W    = $clog2(FPU_N_UNITS);
    localparam int FPU_FLAGS_W  = 5;

    // Result-port index of each execution sub-unit.
    localparam int FPU_UNIT_SGN = 0;
    localparam int FPU_UNIT_ADD = 1;
    localparam int FPU_UNIT_MUL = 2;
    localparam int FPU_UNIT_CLS = 3;
    localparam int FPU_UNIT_DIV = 4;
    localparam int FPU_UNIT_CVT = 5;

    typedef struct packed {
        logic [31:0]            value;
        logic [FPU_FLAGS_W-1:0] fflags;   // NV, DZ, OF, UF, NX
        logic [FPU_UID_W-1:0]   unit_id;
    } fpu_result_t;

endpackage

// File: rtl/fpu_result_arbiter_rr.sv
// Round-robin arbiter, reusable for any request vector.
// Ports:
//   enable      : arbitration allowed this cycle (no grant when low)
//   req         : request vector, one bit per requester
//   ptr         : highest-priority requester index (0..N-1)
//   grant       : one-hot grant (all zero when nothing granted)
//   grant_idx   : binary index of the granted requester
//   grant_valid : a grant was issued
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         enable,
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);

    logic [W-1:0] cand_s;

    // Scan requesters starting at ptr, wrapping at N (N need not be a power of two).
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_s      = '0;
        if (enable) begin
            for (int k = 0; k < N; k++) begin
                cand_s = W'(((int'(ptr) + k) >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k));
                if (req[cand_s] && !grant_valid) begin
                    grant[cand_s] = 1'b1;
                    grant_idx     = cand_s;
                    grant_valid   = 1'b1;
                end else begin
                    grant_valid = grant_valid;
                end
            end
        end else begin
            grant_valid = 1'b0;
        end
    end

endmodule

// File: rtl/fpu_result_arbiter.sv
// Collects results from the FPU execution sub-units, arbitrates round-robin,
// buffers them in a small FIFO and presents one ordered stream to writeback.
// Ports:
//   clk, reset (async, active-high), flush (sync pipeline flush)
//   unit_valid/unit_ready/unit_data/unit_fflags : per-unit result handshake
//   valid_out/ready_in                          : writeback handshake
//   float_out/fflags_out/unit_id_out            : head result (registered, zero when empty)
module fpu_result_arbiter
    import fpu_result_arbiter_pkg::*;
#(
    parameter int N_UNITS = 6,
    parameter int DEPTH   = 2,
    parameter int ID_W    = $clog2(N_UNITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [N_UNITS-1:0]      unit_valid,
    output logic [N_UNITS-1:0]      unit_ready,
    input  logic [N_UNITS-1:0][31:0] unit_data,
    input  logic [N_UNITS-1:0][4:0] unit_fflags,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [31:0]             float_out,
    output logic [4:0]              fflags_out,
    output logic [ID_W-1:0]         unit_id_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [ID_W-1:0]  RR_LAST  = ID_W'(N_UNITS - 1);
    localparam logic [ID_W-1:0]  RR_ONE   = ID_W'(1);

    fpu_result_t        mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_next_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [ID_W-1:0]    rr_next_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [N_UNITS-1:0] grant_s;
    logic               grant_valid_s;
    logic               arb_en_s;
    logic               push_s;
    logic               pop_s;
    fpu_result_t        push_entry_s;
    fpu_result_t        head_next_s;

    logic               valid_r;
    logic [31:0]        float_r;
    logic [4:0]         fflags_r;
    logic [ID_W-1:0]    unit_id_r;

    // No unit may be accepted during reset, flush or while the FIFO is full
    // (a same-cycle pop does not free a slot for a push).
    always_comb begin
        if (reset) begin
            arb_en_s = 1'b0;
        end else if (flush) begin
            arb_en_s = 1'b0;
        end else if (count_r == CNT_FULL) begin
            arb_en_s = 1'b0;
        end else begin
            arb_en_s = 1'b1;
        end
    end

    rr_arbiter #(
        .N (N_UNITS),
        .W (ID_W)
    ) u_rr (
        .enable      (arb_en_s),
        .req         (unit_valid),
        .ptr         (rr_ptr_r),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // unit_ready is the grant alone: nothing from writeback reaches the units.
    assign unit_ready = grant_s;
    assign push_s     = grant_valid_s;
    assign pop_s      = valid_r && ready_in && !flush;

    assign push_entry_s = '{value:   unit_data[grant_idx_s],
                            fflags:  unit_fflags[grant_idx_s],
                            unit_id: FPU_UID_W'(grant_idx_s)};

    // Priority pointer after a grant, wrapped explicitly for non-power-of-two unit counts.
    always_comb begin
        if (grant_idx_s == RR_LAST) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_idx_s + RR_ONE;
        end
    end

    // Next occupancy and read pointer; the output registers are loaded from these.
    always_comb begin
        count_next_s  = count_r;
        rd_ptr_next_s = rd_ptr_r;
        if (flush) begin
            count_next_s  = '0;
            rd_ptr_next_s = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: count_next_s = count_r + CNT_ONE;
                2'b01: begin
                    count_next_s  = count_r - CNT_ONE;
                    rd_ptr_next_s = rd_ptr_r + PTR_ONE;
                end
                2'b11: rd_ptr_next_s = rd_ptr_r + PTR_ONE;
                default: count_next_s = count_r;
            endcase
        end
    end

    // Next head entry; bypass the write when the pushed entry becomes the head
    // (push into empty FIFO, or push+pop with one entry left).
    always_comb begin
        if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = push_entry_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO pointers, occupancy and round-robin pointer (rr_ptr survives flush).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            rr_ptr_r <= '0;
        end else if (flush) begin
            count_r  <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
        end else begin
            count_r  <= count_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                rr_ptr_r <= rr_next_s;
            end
        end
    end

    // Result storage; no reset needed since entries are only read when counted.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_entry_s;
        end
    end

    // Registered writeback outputs, zero whenever the FIFO will be empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r   <= 1'b0;
            float_r   <= 32'h0000_0000;
            fflags_r  <= 5'b00000;
            unit_id_r <= '0;
        end else if (count_next_s != '0) begin
            valid_r   <= 1'b1;
            float_r   <= head_next_s.value;
            fflags_r  <= head_next_s.fflags;
            unit_id_r <= ID_W'(head_next_s.unit_id);
        end else begin
            valid_r   <= 1'b0;
            float_r   <= 32'h0000_0000;
            fflags_r  <= 5'b00000;
            unit_id_r <= '0;
        end
    end

    assign valid_out   = valid_r;
    assign float_out   = float_r;
    assign fflags_out  = fflags_r;
    assign unit_id_out = unit_id_r;

endmodule
